fpdlink_bitslip_ctrl: RTL



---
 rtl/fpdlink_pkg.sv | 17 +
 rtl/fpdlink_bitslip_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/fpdlink_pkg.sv
// Shared FPD-Link I receive-path definitions: word width, clock-lane pattern,
// and the bit-slip controller state encoding.
package fpdlink_pkg;

   localparam int unsigned FPD_WORD_W = 7;

   localparam logic [FPD_WORD_W-1:0] FPD_CLK_PATTERN = 7'b1100011;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_SLIP   = 3'd3,
      ST_LOCKED = 3'd4
   } bitslip_state_t;

endpackage

// File: rtl/fpdlink_bitslip_ctrl.sv
// Clock-lane word aligner: pulses the shared ISERDES bitslip until the
// deserialized clock word matches the expected pattern, then holds lock.
module fpdlink_bitslip_ctrl
   import fpdlink_pkg::*;
#(
   parameter logic [FPD_WORD_W-1:0] CLK_PATTERN   = FPD_CLK_PATTERN,
   parameter int unsigned           SETTLE_CYCLES = 4,
   parameter int unsigned           MATCH_COUNT   = 16,
   parameter int unsigned           MISS_LIMIT    = 4
) (
   input  logic                  gclk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  hold,
   input  logic [FPD_WORD_W-1:0] clk_word,
   output logic                  bitslip,
   output logic                  locked,
   output logic                  align_err,
   output logic [2:0]            slip_pos,
   output logic [7:0]            relock_count
);

   localparam int unsigned SETTLE_W = 4;
   localparam int unsigned CNT_W    = 8;
   localparam logic [2:0]  LAST_POS = 3'd6;

   bitslip_state_t      state;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [CNT_W-1:0]    match_cnt;
   logic [CNT_W-1:0]    miss_cnt;
   logic                word_match_c;

   assign word_match_c = (clk_word == CLK_PATTERN);

   // en low overrides hold; hold freezes everything and only lets bitslip drop
   always_ff @(posedge gclk) begin
      if (rst) begin
         state        <= ST_IDLE;
         settle_cnt   <= '0;
         match_cnt    <= '0;
         miss_cnt     <= '0;
         bitslip      <= 1'b0;
         locked       <= 1'b0;
         align_err    <= 1'b0;
         slip_pos     <= '0;
         relock_count <= '0;
      end else begin
         bitslip <= 1'b0;
         if (!en) begin
            state  <= ST_IDLE;
            locked <= 1'b0;
         end else if (!hold) begin
            unique case (state)
               ST_IDLE: begin
                  settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                  state      <= ST_SETTLE;
               end

               ST_SETTLE: begin
                  settle_cnt <= settle_cnt - 1'b1;
                  if (settle_cnt <= SETTLE_W'(1)) begin
                     match_cnt <= '0;
                     state     <= ST_CHECK;
                  end
               end

               ST_CHECK: begin
                  if (word_match_c) begin
                     if (match_cnt == CNT_W'(MATCH_COUNT - 1)) begin
                        miss_cnt  <= '0;
                        locked    <= 1'b1;
                        align_err <= 1'b0;
                        state     <= ST_LOCKED;
                     end else begin
                        match_cnt <= match_cnt + 1'b1;
                     end
                  end else begin
                     state <= ST_SLIP;
                  end
               end

               // pulse leaves here so a slip deferred by hold is issued exactly once
               ST_SLIP: begin
                  bitslip    <= 1'b1;
                  settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                  state      <= ST_SETTLE;
                  if (slip_pos == LAST_POS) begin
                     slip_pos  <= '0;
                     align_err <= 1'b1;
                  end else begin
                     slip_pos <= slip_pos + 1'b1;
                  end
               end

               // on loss, re-test the current position before slipping again
               ST_LOCKED: begin
                  if (word_match_c) begin
                     miss_cnt <= '0;
                  end else if (miss_cnt == CNT_W'(MISS_LIMIT - 1)) begin
                     miss_cnt  <= '0;
                     match_cnt <= '0;
                     locked    <= 1'b0;
                     state     <= ST_CHECK;
                     if (relock_count != 8'hFF) begin
                        relock_count <= relock_count + 1'b1;
                     end
                  end else begin
                     miss_cnt <= miss_cnt + 1'b1;
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
